tx_dual_buffer_regs: RTL and testbench



---
 rtl/tx_dual_buffer_regs.sv | 128 ++++++++++++
 tb/tb_tx_dual_buffer_regs.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tx_dual_buffer_regs.sv
// rtl/tx_dual_buffer_regs.sv - size/burst control registers plus two MSB-first transmit shift buffers.
// Define TXBUF_BITCOUNT_EN to add per-buffer remaining-bit counters and empty0/empty1 outputs.

module tx_shift_buffer #(
  parameter int BUF_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BUF_W-1:0] data,
  input  logic             load,
  input  logic             shift,
`ifdef TXBUF_BITCOUNT_EN
  output logic             empty,
`endif
  output logic             serial_out
);

  logic [BUF_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data;
    end else if (shift) begin
      shreg <= {shreg[BUF_W-2:0], 1'b0};
    end
  end

  assign serial_out = shreg[BUF_W-1];

`ifdef TXBUF_BITCOUNT_EN
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_W);

  logic [CNT_W-1:0] bit_count;

  // Counts bits still to be presented; saturates at zero on extra shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= '0;
    end else if (load) begin
      bit_count <= FULL_COUNT;
    end else if (shift && (bit_count != '0)) begin
      bit_count <= bit_count - 1'b1;
    end
  end

  assign empty = (bit_count == '0);
`endif

endmodule

module tx_dual_buffer_regs #(
  parameter int         BUF_W      = 32,
  parameter logic [3:0] ADDR_SIZE  = 4'h0,
  parameter logic [3:0] ADDR_BURST = 4'h1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       Tdata,
  input  logic             Twrite,
  input  logic [3:0]       Taddr,
  output logic [7:0]       dataout1,
  output logic [7:0]       dataout2,
  input  logic [BUF_W-1:0] data,
  input  logic             loadB0,
  input  logic             loadB1,
  input  logic             shiftB0,
  input  logic             shiftB1,
`ifdef TXBUF_BITCOUNT_EN
  output logic             empty0,
  output logic             empty1,
`endif
  output logic             buffout0,
  output logic             buffout1
);

  logic [7:0] size_reg;
  logic [7:0] burst_reg;

  // Writes to unmapped addresses are silently dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_reg  <= '0;
      burst_reg <= '0;
    end else if (Twrite) begin
      if (Taddr == ADDR_SIZE) begin
        size_reg <= Tdata;
      end
      if (Taddr == ADDR_BURST) begin
        burst_reg <= Tdata;
      end
    end
  end

  assign dataout1 = size_reg;
  assign dataout2 = burst_reg;

  tx_shift_buffer #(
    .BUF_W(BUF_W)
  ) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .load      (loadB0),
    .shift     (shiftB0),
`ifdef TXBUF_BITCOUNT_EN
    .empty     (empty0),
`endif
    .serial_out(buffout0)
  );

  tx_shift_buffer #(
    .BUF_W(BUF_W)
  ) u_buf1 (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .load      (loadB1),
    .shift     (shiftB1),
`ifdef TXBUF_BITCOUNT_EN
    .empty     (empty1),
`endif
    .serial_out(buffout1)
  );

endmodule

// File: tb/tb_tx_dual_buffer_regs.sv
// tb/tb_tx_dual_buffer_regs.sv - directed self-checking bench for tx_dual_buffer_regs.
// Checks of empty0/empty1 are compiled in when TXBUF_BITCOUNT_EN is defined.

module tb_tx_dual_buffer_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  Tdata;
  logic        Twrite;
  logic [3:0]  Taddr;
  logic [7:0]  dataout1;
  logic [7:0]  dataout2;
  logic [31:0] data;
  logic        loadB0, loadB1, shiftB0, shiftB1;
  logic        buffout0, buffout1;
`ifdef TXBUF_BITCOUNT_EN
  logic        empty0, empty1;
`endif

  int passed = 0;
  int total  = 0;

  tx_dual_buffer_regs #(
    .BUF_W(32), .ADDR_SIZE(4'h0), .ADDR_BURST(4'h1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Tdata   (Tdata),
    .Twrite  (Twrite),
    .Taddr   (Taddr),
    .dataout1(dataout1),
    .dataout2(dataout2),
    .data    (data),
    .loadB0  (loadB0),
    .loadB1  (loadB1),
    .shiftB0 (shiftB0),
    .shiftB1 (shiftB1),
`ifdef TXBUF_BITCOUNT_EN
    .empty0  (empty0),
    .empty1  (empty1),
`endif
    .buffout0(buffout0),
    .buffout1(buffout1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; Twrite = 1'b0; Taddr = 4'h0; Tdata = 8'h00;
    loadB0 = 1'b0; loadB1 = 1'b0; shiftB0 = 1'b0; shiftB1 = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;

    idle();
    data  = 32'h0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_dataout1", {24'h0, dataout1}, 32'h0);
    check("rst_dataout2", {24'h0, dataout2}, 32'h0);
    check("rst_buffout0", {31'h0, buffout0}, 32'h0);
    check("rst_buffout1", {31'h0, buffout1}, 32'h0);
`ifdef TXBUF_BITCOUNT_EN
    check("rst_empty0", {31'h0, empty0}, 32'h1);
    check("rst_empty1", {31'h0, empty1}, 32'h1);
`endif

    // register writes
    Twrite = 1'b1; Taddr = 4'h0; Tdata = 8'h04;
    tick();
    check("wr_size", {24'h0, dataout1}, 32'h04);
    check("wr_size_burst_hold", {24'h0, dataout2}, 32'h0);
    Taddr = 4'h1; Tdata = 8'h03;
    tick();
    check("wr_burst_size", {24'h0, dataout1}, 32'h04);
    check("wr_burst", {24'h0, dataout2}, 32'h03);
    Taddr = 4'h7; Tdata = 8'hFF;
    tick();
    check("wr_unmapped_size", {24'h0, dataout1}, 32'h04);
    check("wr_unmapped_burst", {24'h0, dataout2}, 32'h03);
    Twrite = 1'b0; Taddr = 4'h0; Tdata = 8'hAA;
    tick();
    check("no_write_size", {24'h0, dataout1}, 32'h04);
    check("no_write_burst", {24'h0, dataout2}, 32'h03);

    // load + full shift-out of buffer 0
    idle();
    data = 32'hA5000001; loadB0 = 1'b1;
    tick();
    loadB0 = 1'b0;
    seq = 32'hA5000001;
    check("load_b0_bit31", {31'h0, buffout0}, 32'h1);
    check("load_b0_b1_idle", {31'h0, buffout1}, 32'h0);
`ifdef TXBUF_BITCOUNT_EN
    check("load_empty0", {31'h0, empty0}, 32'h0);
`endif
    for (int i = 1; i <= 33; i++) begin
      shiftB0 = 1'b1;
      tick();
      if (i < 32) begin
        check($sformatf("shift_b0_%0d", i), {31'h0, buffout0}, {31'h0, seq[31-i]});
      end else begin
        check($sformatf("shift_b0_%0d", i), {31'h0, buffout0}, 32'h0);
      end
`ifdef TXBUF_BITCOUNT_EN
      if (i == 31) check("empty0_after31", {31'h0, empty0}, 32'h0);
      if (i == 32) check("empty0_after32", {31'h0, empty0}, 32'h1);
      if (i == 33) check("empty0_saturate", {31'h0, empty0}, 32'h1);
`endif
    end
    shiftB0 = 1'b0;

    // load wins over shift; buffer 0 untouched
    data = 32'hC0000000; loadB0 = 1'b1;
    tick();
    loadB0 = 1'b0;
    data = 32'h80000000; loadB1 = 1'b1; shiftB1 = 1'b1;
    tick();
    check("load_wins_b1", {31'h0, buffout1}, 32'h1);
    check("load_wins_b0_hold", {31'h0, buffout0}, 32'h1);
    loadB1 = 1'b0;
    // concurrent shift of both buffers and a register write
    shiftB0 = 1'b1; Twrite = 1'b1; Taddr = 4'h0; Tdata = 8'h5A;
    tick();
    check("concurrent_b1", {31'h0, buffout1}, 32'h0);
    check("concurrent_b0", {31'h0, buffout0}, 32'h1);
    check("concurrent_size", {24'h0, dataout1}, 32'h5A);
    check("concurrent_burst", {24'h0, dataout2}, 32'h03);
    idle();
    shiftB0 = 1'b1;
    tick();
    check("b0_c0_second_shift", {31'h0, buffout0}, 32'h0);

    // reset mid-shift
    idle();
    data = 32'hFFFFFFFF; loadB0 = 1'b1; loadB1 = 1'b1;
    tick();
    loadB0 = 1'b0; loadB1 = 1'b0; shiftB0 = 1'b1; shiftB1 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_shift_b0", {31'h0, buffout0}, 32'h1);
    check("mid_shift_b1", {31'h0, buffout1}, 32'h1);
    reset = 1'b1; loadB0 = 1'b1; loadB1 = 1'b1;
    Twrite = 1'b1; Taddr = 4'h1; Tdata = 8'h77;
    tick();
    check("rst2_dataout1", {24'h0, dataout1}, 32'h0);
    check("rst2_dataout2", {24'h0, dataout2}, 32'h0);
    check("rst2_buffout0", {31'h0, buffout0}, 32'h0);
    check("rst2_buffout1", {31'h0, buffout1}, 32'h0);
`ifdef TXBUF_BITCOUNT_EN
    check("rst2_empty0", {31'h0, empty0}, 32'h1);
    check("rst2_empty1", {31'h0, empty1}, 32'h1);
`endif
    idle();
    shiftB0 = 1'b1; shiftB1 = 1'b1;
    tick();
    check("post_rst_buffout0", {31'h0, buffout0}, 32'h0);
    check("post_rst_buffout1", {31'h0, buffout1}, 32'h0);
`ifdef TXBUF_BITCOUNT_EN
    check("post_rst_empty0", {31'h0, empty0}, 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
